// File: rtl/range_coalesce.sv
// range_coalesce: streams the sorted range list out of the final ping-pong bank
// (two ranges per word). Overlapping and adjacent inclusive ranges are merged in a
// single pass. Outputs are the number of distinct IDs covered and the number of
// coalesced ranges.

`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 4
`endif

module range_coalesce #(
  parameter int unsigned ID_W    = 64,
  parameter int unsigned TOTAL_W = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start_in,
  input  logic                        bank_sel_in,
  input  logic [`BANK_ADDR_WIDTH:0]   num_ranges_in,
  input  logic [2*ID_W-1:0]           even_data_in,
  input  logic [2*ID_W-1:0]           odd_data_in,
  output logic                        read_en_out,
  output logic [`BANK_ADDR_WIDTH-1:0] read_addr_out,
  output logic                        read_bank_out,
  output logic                        busy_out,
  output logic                        done_out,
  output logic [TOTAL_W-1:0]          total_out,
  output logic [`BANK_ADDR_WIDTH:0]   ranges_out
);

  localparam int unsigned AW   = `BANK_ADDR_WIDTH;
  localparam int unsigned LenW = ID_W + 1;
  localparam int unsigned SumW = (TOTAL_W > LenW) ? TOTAL_W : LenW;
  localparam int unsigned IdxW = AW + 2;

  typedef enum logic [2:0] {StIdle, StFetch, StEven, StOdd, StFlush, StDone} state_e;

  state_e              state_q;
  logic [AW:0]         num_q;
  logic [AW-1:0]       word_q;
  logic                active_q;
  logic [ID_W-1:0]     cur_lo_q;
  logic [ID_W-1:0]     cur_hi_q;
  logic [2*ID_W-1:0]   hold_q;

  // Entry indices are kept one bit wider than the count so 2w+2 cannot wrap.
  logic [IdxW-1:0] num_ext;
  logic [IdxW-1:0] odd_idx;
  logic [IdxW-1:0] next_even_idx;
  logic            odd_valid;
  logic            more_words;

  assign num_ext       = {1'b0, num_q};
  assign odd_idx       = {1'b0, word_q, 1'b1};
  assign next_even_idx = {1'b0, word_q, 1'b0} + IdxW'(2);
  assign odd_valid     = odd_idx < num_ext;
  assign more_words    = next_even_idx < num_ext;

  // Bank read strobe: first word from FETCH, following words issued from ODD.
  always_comb begin
    read_en_out   = 1'b0;
    read_addr_out = '0;
    if (state_q == StFetch) begin
      read_en_out = 1'b1;
    end else if (state_q == StOdd && more_words) begin
      read_en_out   = 1'b1;
      read_addr_out = word_q + AW'(1);
    end
  end

  logic [ID_W-1:0]    r_lo;
  logic [ID_W-1:0]    r_hi;
  logic               touches;
  logic [LenW-1:0]    cur_len;
  logic [SumW-1:0]    sum_wide;
  logic [TOTAL_W-1:0] total_plus;
  logic [ID_W-1:0]    nxt_lo;
  logic [ID_W-1:0]    nxt_hi;
  logic [TOTAL_W-1:0] nxt_total;
  logic [AW:0]        nxt_ranges;

  // Merge step for the entry being consumed this cycle (even input or held odd).
  always_comb begin
    {r_lo, r_hi} = (state_q == StOdd) ? hold_q : even_data_in;
    // Widened compare so cur_hi = all-ones still accepts any following range.
    touches    = {1'b0, r_lo} <= ({1'b0, cur_hi_q} + LenW'(1));
    cur_len    = {1'b0, cur_hi_q} - {1'b0, cur_lo_q} + LenW'(1);
    sum_wide   = SumW'(total_out) + SumW'(cur_len);
    total_plus = sum_wide[TOTAL_W-1:0];
    nxt_lo     = r_lo;
    nxt_hi     = r_hi;
    nxt_total  = total_out;
    nxt_ranges = ranges_out;
    if (active_q && touches) begin
      nxt_lo = cur_lo_q;
      nxt_hi = (r_hi > cur_hi_q) ? r_hi : cur_hi_q;
    end else if (active_q) begin
      nxt_total  = total_plus;
      nxt_ranges = ranges_out + (AW + 1)'(1);
    end
  end

  // Control FSM with registered status/result outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      num_q         <= '0;
      word_q        <= '0;
      active_q      <= 1'b0;
      cur_lo_q      <= '0;
      cur_hi_q      <= '0;
      hold_q        <= '0;
      read_bank_out <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      total_out     <= '0;
      ranges_out    <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_in) begin
            read_bank_out <= bank_sel_in;
            num_q         <= num_ranges_in;
            word_q        <= '0;
            active_q      <= 1'b0;
            total_out     <= '0;
            ranges_out    <= '0;
            done_out      <= 1'b0;
            busy_out      <= 1'b1;
            state_q       <= (num_ranges_in == '0) ? StFlush : StFetch;
          end
        end
        StFetch: state_q <= StEven;
        StEven: begin
          cur_lo_q   <= nxt_lo;
          cur_hi_q   <= nxt_hi;
          total_out  <= nxt_total;
          ranges_out <= nxt_ranges;
          active_q   <= 1'b1;
          hold_q     <= odd_data_in;
          state_q    <= odd_valid ? StOdd : StFlush;
        end
        StOdd: begin
          cur_lo_q   <= nxt_lo;
          cur_hi_q   <= nxt_hi;
          total_out  <= nxt_total;
          ranges_out <= nxt_ranges;
          active_q   <= 1'b1;
          if (more_words) begin
            word_q  <= word_q + AW'(1);
            state_q <= StEven;
          end else begin
            state_q <= StFlush;
          end
        end
        StFlush: begin
          if (active_q) begin
            total_out  <= total_plus;
            ranges_out <= ranges_out + (AW + 1)'(1);
          end
          active_q <= 1'b0;
          done_out <= 1'b1;
          busy_out <= 1'b0;
          state_q  <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_range_coalesce.sv
// Bench for range_coalesce: bank memory responder, scoreboard of expected results,
// bitmap reference model for small-valued random range lists.

`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 4
`endif

module tb_range_coalesce;

  localparam int AW      = `BANK_ADDR_WIDTH;
  localparam int ID_W    = 64;
  localparam int TOTAL_W = 64;
  localparam int MemE    = 2 ** (AW + 1);
  localparam int MaxN    = MemE - 1;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 start_in = 1'b0;
  logic                 bank_sel_in = 1'b0;
  logic [AW:0]          num_ranges_in = '0;
  logic [2*ID_W-1:0]    even_data_in = '0;
  logic [2*ID_W-1:0]    odd_data_in = '0;
  logic                 read_en_out;
  logic [AW-1:0]        read_addr_out;
  logic                 read_bank_out;
  logic                 busy_out;
  logic                 done_out;
  logic [TOTAL_W-1:0]   total_out;
  logic [AW:0]          ranges_out;

  range_coalesce #(.ID_W(ID_W), .TOTAL_W(TOTAL_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .start_in      (start_in),
    .bank_sel_in   (bank_sel_in),
    .num_ranges_in (num_ranges_in),
    .even_data_in  (even_data_in),
    .odd_data_in   (odd_data_in),
    .read_en_out   (read_en_out),
    .read_addr_out (read_addr_out),
    .read_bank_out (read_bank_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .total_out     (total_out),
    .ranges_out    (ranges_out)
  );

  always #5 clock = ~clock;

  logic [ID_W-1:0] mem_lo [MemE];
  logic [ID_W-1:0] mem_hi [MemE];

  typedef struct {
    logic [TOTAL_W-1:0] total;
    logic [AW:0]        ranges;
    int                 n;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   exp_addr = 0;
  int   n_reads = 0;
  logic exp_bank = 1'b0;
  logic done_prev = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Bank memory with one-cycle read latency.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (read_en_out) begin
      even_data_in <= {mem_lo[2*read_addr_out], mem_hi[2*read_addr_out]};
      odd_data_in  <= {mem_lo[2*read_addr_out+1], mem_hi[2*read_addr_out+1]};
    end
  end

  // Monitor: read address sequence, and results on each rising done_out.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && read_en_out) begin
      chk("read_addr", 128'(read_addr_out), 128'(exp_addr));
      chk("read_bank", 128'(read_bank_out), 128'(exp_bank));
      exp_addr++;
      n_reads++;
    end
    if (!reset && done_out && !done_prev) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done_out=1, expected no pending pass");
      end else begin
        e = sb.pop_front();
        chk("total_out", 128'(total_out), 128'(e.total));
        chk("ranges_out", 128'(ranges_out), 128'(e.ranges));
        chk("read_count", 128'(n_reads), 128'((e.n + 1) / 2));
        chk("busy_at_done", 128'(busy_out), 128'(0));
        if (e.n > 0) chk("done_latency", 128'(cyc - start_cyc), 128'(e.n + 2));
      end
    end
    done_prev = done_out;
  end

  task automatic clear_mem();
    for (int k = 0; k < MemE; k++) begin
      mem_lo[k] = '1;
      mem_hi[k] = '1;
    end
  endtask

  task automatic ld(input int k, input logic [ID_W-1:0] lo, input logic [ID_W-1:0] hi);
    mem_lo[k] = lo;
    mem_hi[k] = hi;
  endtask

  // Reference: mark every covered ID in a bitmap, then count set bits and runs.
  function automatic void model(input int n, output logic [TOTAL_W-1:0] t, output int r);
    logic [255:0] bm;
    bm = '0;
    for (int k = 0; k < n; k++)
      for (int v = int'(mem_lo[k]); v <= int'(mem_hi[k]); v++) bm[v] = 1'b1;
    t = '0;
    r = 0;
    for (int v = 0; v < 256; v++) begin
      if (bm[v]) t++;
      if (bm[v] && (v == 0 || !bm[v-1])) r++;
    end
  endfunction

  task automatic pulse(input logic bank, input int n);
    @(negedge clock);
    start_in      = 1'b1;
    bank_sel_in   = bank;
    num_ranges_in = n[AW:0];
    @(negedge clock);
    start_in = 1'b0;
  endtask

  task automatic run_pass(input logic bank, input int n, input logic [TOTAL_W-1:0] et,
                          input int er, input bit glitch);
    exp_t e;
    e.total  = et;
    e.ranges = er[AW:0];
    e.n      = n;
    sb.push_back(e);
    exp_addr = 0;
    n_reads  = 0;
    exp_bank = bank;
    pulse(bank, n);
    start_cyc = cyc;
    if (glitch) begin
      @(negedge clock);
      pulse(~bank, 0);
      chk("busy_after_ignored_start", 128'(busy_out), 128'(1));
    end
    for (int i = 0; i < 200 && !done_out; i++) @(negedge clock);
    if (!done_out) begin
      n_checks++;
      $display("FAIL done_timeout: got done_out=0 after 200 cycles, expected 1");
      if (sb.size() > 0) void'(sb.pop_back());
    end
    @(negedge clock);
  endtask

  initial begin
    logic [TOTAL_W-1:0] t;
    int                 r;
    int                 n;
    int                 span;
    int                 lq[$];
    logic [ID_W-1:0]    max_id;

    max_id = '1;
    clear_mem();
    repeat (3) @(negedge clock);
    chk("reset_busy", 128'(busy_out), 128'(0));
    chk("reset_done", 128'(done_out), 128'(0));
    chk("reset_total", 128'(total_out), 128'(0));
    chk("reset_ranges", 128'(ranges_out), 128'(0));
    chk("reset_read_en", 128'(read_en_out), 128'(0));
    chk("reset_read_addr", 128'(read_addr_out), 128'(0));
    chk("reset_read_bank", 128'(read_bank_out), 128'(0));
    reset = 1'b0;
    @(negedge clock);

    // Overlapping chain.
    clear_mem();
    ld(0, 3, 5); ld(1, 10, 14); ld(2, 12, 18); ld(3, 16, 20);
    run_pass(1'b0, 4, 14, 2, 1'b0);

    // Adjacent ranges, odd entry of word 1 is padding.
    clear_mem();
    ld(0, 1, 2); ld(1, 3, 4); ld(2, 6, 6);
    run_pass(1'b0, 3, 5, 2, 1'b0);

    // Empty list.
    clear_mem();
    run_pass(1'b0, 0, 0, 0, 1'b0);

    // Top of the ID space: adjacency compare must not wrap.
    clear_mem();
    ld(0, 0, 0); ld(1, max_id - 1, max_id); ld(2, max_id, max_id);
    run_pass(1'b0, 3, 3, 2, 1'b0);

    // Containment.
    clear_mem();
    ld(0, 5, 100); ld(1, 10, 20); ld(2, 30, 40);
    run_pass(1'b0, 3, 96, 1, 1'b0);

    // Start pulsed mid-pass must be ignored; bank 1 shown on read_bank_out.
    clear_mem();
    ld(0, 2, 3); ld(1, 5, 9); ld(2, 8, 8); ld(3, 20, 25);
    ld(4, 26, 30); ld(5, 40, 40); ld(6, 41, 50);
    model(7, t, r);
    run_pass(1'b1, 7, t, r, 1'b1);

    // Reset while in EVEN aborts the pass.
    clear_mem();
    ld(0, 100, 200); ld(1, 150, 220); ld(2, 230, 240);
    exp_addr = 0;
    n_reads  = 0;
    exp_bank = 1'b1;
    pulse(1'b1, 3);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_busy", 128'(busy_out), 128'(0));
    chk("abort_done", 128'(done_out), 128'(0));
    chk("abort_total", 128'(total_out), 128'(0));
    chk("abort_ranges", 128'(ranges_out), 128'(0));
    chk("abort_read_en", 128'(read_en_out), 128'(0));
    chk("abort_read_bank", 128'(read_bank_out), 128'(0));
    @(negedge clock);
    reset = 1'b0;
    clear_mem();
    ld(0, 7, 9);
    run_pass(1'b0, 1, 3, 1, 1'b0);

    // Random sorted lists against the bitmap model.
    for (int p = 0; p < 24; p++) begin
      clear_mem();
      n    = (p == 0) ? MaxN : $urandom_range(1, MaxN);
      span = ($urandom_range(0, 1) == 1) ? 3 : 30;
      lq.delete();
      for (int k = 0; k < n; k++) lq.push_back($urandom_range(0, 200));
      lq.sort();
      for (int k = 0; k < n; k++) ld(k, lq[k], lq[k] + $urandom_range(0, span));
      model(n, t, r);
      run_pass(1'($urandom_range(0, 1)), n, t, r, 1'b0);
    end

    repeat (3) @(negedge clock);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
